// File: rtl/busca_instrucao.sv
// Instruction fetch stage: reads a 16-bit big-endian instruction
// as two byte reads and holds it until decode accepts it.
module busca_instrucao #(
   parameter logic [15:0] NOP = 16'h0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] endereco,
   input  logic        stall,
   input  logic        flush,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack,
   output logic [15:0] instrucao,
   output logic [15:0] pc_instr,
   output logic        valid,
   output logic        pc_avanca,
   output logic        erro_alinhamento
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] BYTE_HI = 2'd1;
   localparam logic [1:0] BYTE_LO = 2'd2;
   localparam logic [1:0] HOLD    = 2'd3;

   logic [1:0]  state;
   logic [15:0] pc_lat;
   logic [15:0] instr_q;

   assign mem_req   = (state == BYTE_HI) || (state == BYTE_LO);
   assign pc_avanca = (state == HOLD) && !stall && !flush;
   assign instrucao = valid ? instr_q : NOP;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         pc_lat           <= 16'h0000;
         mem_addr         <= 16'h0000;
         instr_q          <= NOP;
         pc_instr         <= 16'h0000;
         valid            <= 1'b0;
         erro_alinhamento <= 1'b0;
      end else if (flush) begin
         // a flush drops both the fetch in flight and the held word
         state <= IDLE;
         valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!erro_alinhamento) begin
                  if (endereco[0]) begin
                     erro_alinhamento <= 1'b1;
                  end else begin
                     pc_lat   <= endereco;
                     mem_addr <= endereco;
                     state    <= BYTE_HI;
                  end
               end
            end
            BYTE_HI: begin
               if (mem_ack) begin
                  instr_q[15:8] <= mem_rdata;
                  mem_addr      <= pc_lat + 16'd1;
                  state         <= BYTE_LO;
               end
            end
            BYTE_LO: begin
               if (mem_ack) begin
                  instr_q[7:0] <= mem_rdata;
                  pc_instr     <= pc_lat;
                  valid        <= 1'b1;
                  state        <= HOLD;
               end
            end
            HOLD: begin
               if (!stall) begin
                  valid <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: vector table of fetches plus
// hand-written stall, flush, alignment and async-reset sequences.
module tb_busca_instrucao;

   localparam logic [15:0] NOPV = 16'hF00D;

   logic        clock;
   logic        reset;
   logic [15:0] endereco;
   logic        stall;
   logic        flush;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [7:0]  mem_rdata;
   logic        mem_ack;
   logic [15:0] instrucao;
   logic [15:0] pc_instr;
   logic        valid;
   logic        pc_avanca;
   logic        erro_alinhamento;

   logic        ack_en;
   logic [3:0]  wait_n;
   logic [3:0]  wcnt;

   int n_tests;
   int n_fail;

   busca_instrucao #(.NOP(NOPV)) dut (
      .clock            (clock),
      .reset            (reset),
      .endereco         (endereco),
      .stall            (stall),
      .flush            (flush),
      .mem_req          (mem_req),
      .mem_addr         (mem_addr),
      .mem_rdata        (mem_rdata),
      .mem_ack          (mem_ack),
      .instrucao        (instrucao),
      .pc_instr         (pc_instr),
      .valid            (valid),
      .pc_avanca        (pc_avanca),
      .erro_alinhamento (erro_alinhamento)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // memory: 0->12, 1->34, else addr_hi ^ addr_lo ^ A5
   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      if (a == 16'd0) return 8'h12;
      if (a == 16'd1) return 8'h34;
      return a[15:8] ^ a[7:0] ^ 8'hA5;
   endfunction

   assign mem_rdata = mem_byte(mem_addr);
   assign mem_ack   = ack_en && mem_req && (wcnt == wait_n);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) wcnt <= 4'd0;
      else if (mem_req && !mem_ack) wcnt <= wcnt + 4'd1;
      else wcnt <= 4'd0;
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset(input logic [15:0] a, input logic [3:0] wn,
                           input logic st);
      reset    = 1'b0;
      flush    = 1'b0;
      stall    = st;
      endereco = a;
      wait_n   = wn;
      ack_en   = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic wait_valid(input string name, output int cyc);
      cyc = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         if (valid) begin
            cyc = k;
            break;
         end
      end
      if (cyc == 0) check({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   typedef struct {
      logic [15:0] addr;
      logic [3:0]  wn;
      logic [15:0] exp_instr;
      int          exp_cyc;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int cyc;
      int gaps;
      int pulses;
      logic [15:0] first_a;
      logic [15:0] last_a;
      logic        saw_req;

      n_tests = 0;
      n_fail  = 0;
      reset    = 1'b0;
      stall    = 1'b0;
      flush    = 1'b0;
      endereco = 16'h0000;
      ack_en   = 1'b1;
      wait_n   = 4'd0;

      vecs[0] = '{16'h0000, 4'd0, 16'h1234, 3};
      vecs[1] = '{16'h0002, 4'd0, 16'hA7A6, 3};
      vecs[2] = '{16'h0000, 4'd2, 16'h1234, 7};
      vecs[3] = '{16'hFFFE, 4'd0, 16'hA4A5, 3};
      vecs[4] = '{16'd46,   4'd1, 16'h8B8A, 5};

      // reset values with reset held low
      #3;
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_instr", 32'(instrucao), 32'(NOPV));
      check("rst_pc_instr", 32'(pc_instr), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_pc_avanca", 32'(pc_avanca), 32'd0);
      check("rst_erro", 32'(erro_alinhamento), 32'd0);

      // table of complete fetches
      for (int v = 0; v < 5; v++) begin
         do_reset(vecs[v].addr, vecs[v].wn, 1'b0);
         gaps    = 0;
         cyc     = 0;
         first_a = 16'hXXXX;
         last_a  = 16'hXXXX;
         for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (valid) begin
               cyc = k;
               break;
            end
            if (!mem_req) gaps++;
            if (k == 1) first_a = mem_addr;
            last_a = mem_addr;
         end
         check($sformatf("v%0d_cycles", v), 32'(cyc), 32'(vecs[v].exp_cyc));
         check($sformatf("v%0d_instr", v), 32'(instrucao),
               32'(vecs[v].exp_instr));
         check($sformatf("v%0d_pc_instr", v), 32'(pc_instr),
               32'(vecs[v].addr));
         check($sformatf("v%0d_addr_hi", v), 32'(first_a),
               32'(vecs[v].addr));
         check($sformatf("v%0d_addr_lo", v), 32'(last_a),
               32'(vecs[v].addr + 16'd1));
         check($sformatf("v%0d_req_gaps", v), 32'(gaps), 32'd0);
         check($sformatf("v%0d_avanca", v), 32'(pc_avanca), 32'd1);
         @(negedge clock);
         check($sformatf("v%0d_valid_drop", v), 32'(valid), 32'd0);
         check($sformatf("v%0d_nop", v), 32'(instrucao), 32'(NOPV));
      end

      // stall holds the instruction for 5 cycles
      do_reset(16'h0000, 4'd0, 1'b1);
      wait_valid("stall_fetch", cyc);
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         check("stall_instr", 32'(instrucao), 32'h1234);
         check("stall_valid", 32'(valid), 32'd1);
         check("stall_avanca", 32'(pc_avanca), 32'd0);
      end
      endereco = 16'h0002;
      stall    = 1'b0;
      #1;
      check("stall_release_avanca", 32'(pc_avanca), 32'd1);
      pulses = 0;
      cyc    = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         if (valid) begin
            cyc = k;
            break;
         end
         pulses += int'(pc_avanca);
      end
      check("stall_extra_pulses", 32'(pulses), 32'd0);
      check("stall_next_cycles", 32'(cyc), 32'd4);
      check("stall_next_instr", 32'(instrucao), 32'hA7A6);
      check("stall_next_pc", 32'(pc_instr), 32'd2);

      // flush while holding suppresses pc_avanca
      flush = 1'b1;
      #1;
      check("flush_hold_avanca", 32'(pc_avanca), 32'd0);
      @(negedge clock);
      flush = 1'b0;
      check("flush_hold_valid", 32'(valid), 32'd0);
      check("flush_hold_nop", 32'(instrucao), 32'(NOPV));

      // flush in BYTE_LO together with mem_ack
      do_reset(16'h0000, 4'd0, 1'b0);
      @(negedge clock);
      @(negedge clock);
      check("flush_lo_addr", 32'(mem_addr), 32'd1);
      check("flush_lo_ack", 32'(mem_ack), 32'd1);
      flush    = 1'b1;
      endereco = 16'd46;
      #1;
      check("flush_lo_avanca", 32'(pc_avanca), 32'd0);
      @(negedge clock);
      flush = 1'b0;
      check("flush_lo_valid", 32'(valid), 32'd0);
      check("flush_lo_nop", 32'(instrucao), 32'(NOPV));
      check("flush_lo_req", 32'(mem_req), 32'd0);
      wait_valid("flush_refetch", cyc);
      check("flush_refetch_cycles", 32'(cyc), 32'd3);
      check("flush_refetch_instr", 32'(instrucao), 32'h8B8A);
      check("flush_refetch_pc", 32'(pc_instr), 32'd46);

      // odd address: sticky error, no request
      do_reset(16'd7, 4'd0, 1'b0);
      saw_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         saw_req |= mem_req;
      end
      check("odd_erro", 32'(erro_alinhamento), 32'd1);
      endereco = 16'd8;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         saw_req |= mem_req;
      end
      check("odd_no_req", 32'(saw_req), 32'd0);
      check("odd_sticky", 32'(erro_alinhamento), 32'd1);
      reset = 1'b0;
      #1;
      check("odd_clear", 32'(erro_alinhamento), 32'd0);

      // async reset in the middle of BYTE_HI
      do_reset(16'h0002, 4'd0, 1'b0);
      ack_en = 1'b0;
      @(negedge clock);
      check("ar_req", 32'(mem_req), 32'd1);
      check("ar_addr", 32'(mem_addr), 32'd2);
      #2;
      reset = 1'b0;
      #1;
      check("ar_req_now", 32'(mem_req), 32'd0);
      check("ar_addr_now", 32'(mem_addr), 32'd0);
      check("ar_valid_now", 32'(valid), 32'd0);
      check("ar_instr_now", 32'(instrucao), 32'(NOPV));
      @(negedge clock);
      ack_en = 1'b1;
      reset  = 1'b1;
      @(negedge clock);
      check("ar_first_req", 32'(mem_req), 32'd1);
      check("ar_first_addr", 32'(mem_addr), 32'd2);
      wait_valid("ar_fetch", cyc);
      check("ar_fetch_instr", 32'(instrucao), 32'hA7A6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
